// File: rtl/buffer_rr_arbiter_pkg.sv
// Shared defaults, buffer state encoding and index-width helper for the
// round-robin buffer arbiter.
package buffer_rr_arbiter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // A single requester index still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDXW_DEF = idx_width(NREQ_DEF);

endpackage

// File: rtl/buffer_rr_arbiter_rr_pick.sv
// purpose: round-robin winner search starting just after last_ptr, wrapping at NREQ-1
// latency: combinational
// backpressure: none; the caller decides whether the winner is used
module buffer_rr_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_ptr,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    // Walk offsets from farthest to nearest so the nearest asserted req
    // overwrites earlier hits and ends up as the winner.
    always_comb begin
        int cand;
        winner  = '0;
        any_req = |req;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_ptr) + k) % NREQ;
            if (req[cand]) begin
                winner = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/buffer_rr_arbiter.sv
// purpose: round-robin share of one registered WIDTH-bit buffer among NREQ producers
// latency: 1 cycle from req to out_valid/grant; one word per cycle sustained
// backpressure: word held while out_valid && !out_ready; no arbitration until accepted
module buffer_rr_arbiter
    import buffer_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDXW  = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDXW-1:0]       out_src,
    output logic                  busy
);

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic [IDXW-1:0] last_ptr;
    logic [IDXW-1:0] winner;
    logic            any_req;

    buffer_rr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Acceptance and refill share one edge for back-to-back transfers.
                if (out_ready) begin
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer resets to the last index so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
            last_ptr <= IDXW'(NREQ - 1);
            grant    <= '0;
        end else begin
            grant <= '0;
            if (load) begin
                out_data <= data_in[int'(winner)*WIDTH +: WIDTH];
                out_src  <= winner;
                last_ptr <= winner;
                grant    <= NREQ'(1) << winner;
            end
        end
    end

    assign out_valid = (state == ST_FULL);
    assign busy      = out_valid;

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Directed bench for buffer_rr_arbiter: a queue-free behavioural model is compared
// every cycle, plus literal expectations at the key points of each scenario.
module tb_buffer_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDXW  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDXW-1:0]       out_src;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;

    buffer_rr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDXW  (IDXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: buffer holds a word or not, pointer is the last winner.
    bit       m_valid;
    int       m_data;
    int       m_src;
    int       m_last;
    int       m_grant;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_data  = 0;
            m_src   = 0;
            m_last  = NREQ - 1;
            m_grant = 0;
        end else begin
            int w;
            bit found;
            found = 0;
            w     = 0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req[c]) begin
                    w     = c;
                    found = 1;
                    break;
                end
            end
            m_grant = 0;
            if ((!m_valid || out_ready) && found) begin
                m_data  = int'(data_in[w*WIDTH +: WIDTH]);
                m_src   = w;
                m_last  = w;
                m_grant = 1 << w;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid", int'(out_valid), int'(m_valid));
        chk("model_busy",  int'(busy),      int'(m_valid));
        chk("model_grant", int'(grant),     m_grant);
        chk("model_data",  int'(out_data),  m_data);
        chk("model_src",   int'(out_src),   m_src);
        chk("grant_onehot0", int'($onehot0(grant)), 1);
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        data_in   = {8'h49, 8'hC0, 8'h0A, 8'h00};

        // Reset held with all requests asserted.
        repeat (3) step();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_data",  int'(out_data), 8'h00);

        // Release; fairness across all four requesters with wrap to 0.
        rst_n = 1'b1;
        step(); chk("fair_g0", int'(grant), 4'b0001); chk("fair_d0", int'(out_data), 8'h00);
        step(); chk("fair_g1", int'(grant), 4'b0010); chk("fair_d1", int'(out_data), 8'h0A);
        step(); chk("fair_g2", int'(grant), 4'b0100); chk("fair_d2", int'(out_data), 8'hC0);
        step(); chk("fair_g3", int'(grant), 4'b1000); chk("fair_d3", int'(out_data), 8'h49);
        step(); chk("fair_g4", int'(grant), 4'b0001); chk("fair_d4", int'(out_data), 8'h00);

        // No requests with ready: drain to IDLE, data holds.
        req = 4'b0000;
        step();
        chk("drain_valid", int'(out_valid), 0);
        chk("drain_data",  int'(out_data), 8'h00);
        step();
        chk("idle_grant", int'(grant), 0);

        // Single source.
        data_in[2*WIDTH +: WIDTH] = 8'hB0;
        req = 4'b0100;
        step();
        chk("single_grant", int'(grant), 4'b0100);
        chk("single_data",  int'(out_data), 8'hB0);
        chk("single_src",   int'(out_src), 2);
        chk("single_valid", int'(out_valid), 1);
        req = 4'b0000;
        step();
        chk("single_drop_valid", int'(out_valid), 0);

        // Back-pressure: load 0x46 from requester 0, then stall 5 cycles.
        out_ready = 1'b0;
        data_in[0*WIDTH +: WIDTH] = 8'h46;
        req = 4'b0001;
        step();
        chk("bp_load_grant", int'(grant), 4'b0001);
        chk("bp_load_data",  int'(out_data), 8'h46);
        req = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data",  int'(out_data), 8'h46);
            chk("bp_hold_grant", int'(grant), 0);
            chk("bp_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_grant", int'(grant), 4'b0010);
        chk("bp_next_data",  int'(out_data), 8'h0A);
        chk("bp_next_src",   int'(out_src), 1);
        req = 4'b1000;
        step();
        chk("bp_after_grant", int'(grant), 4'b1000);

        // Wrap: last winner is 3, requesters 0 and 3 pending -> 0 wins.
        req = 4'b1001;
        step();
        chk("wrap_grant", int'(grant), 4'b0001);
        chk("wrap_src",   int'(out_src), 0);

        // Reset while FULL with 0x24.
        data_in[2*WIDTH +: WIDTH] = 8'h24;
        req = 4'b0100;
        step();
        chk("pre_rst_data", int'(out_data), 8'h24);
        out_ready = 1'b0;
        req = 4'b0000;
        step();
        chk("pre_rst_valid", int'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data",  int'(out_data), 8'h00);
        req = 4'b1000;
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_grant", int'(grant), 4'b1000);
        chk("post_rst_src",   int'(out_src), 3);
        chk("post_rst_data",  int'(out_data), 8'h49);
        req = 4'b0000;
        out_ready = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
